tlc_input_cond: RTL
===================

# tlc_input_cond

Input-conditioning front end for the s444 traffic-light controller. Drives the controller's three primary inputs:
- G0: synchronous clear.
- G1: timebase tick.
- G2: vehicle/pedestrian request.

It generates them from a raw asynchronous sensor line and a free-running clock. It sits directly upstream of the controller, in the same CK domain. It guarantees a clean power-on clear, a single-cycle prescaled tick, and a metastability-safe, debounced request.

## Interface
- PRESCALE, 16: CK cycles per G1 tick; must be >= 1.
- DEB_LEN, 4: consecutive synchronized samples of disagreement required to change the debounced request; must be >= 1.
- CLR_LEN, 8: CK rising edges G0 is held after RST deasserts or after a clear request; must be >= 1.
- CK  in  1  clock, rising-edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- SENSOR  in  1  raw asynchronous request input.
- ENABLE  in  1  synchronous; 1 = prescaler counts, 0 = prescaler holds and G1 = 0.
- CLR_REQ  in  1  synchronous; 1 for one or more cycles = re-enter clear sequence.
- G0  out  1  clear to controller, registered.
- G1  out  1  tick pulse to controller, registered, one CK wide.
- G2  out  1  conditioned request to controller, registered.

## Operation

**Clear FSM**, states CLEAR and RUN.
- RST forces CLEAR with clr_cnt = 0.
- In CLEAR, clr_cnt increments each edge. At the edge where clr_cnt would reach CLR_LEN, the FSM moves to RUN.
- In RUN, CLR_REQ = 1 moves to CLEAR with clr_cnt = 0 at the next edge.
- CLR_REQ = 1 while in CLEAR restarts clr_cnt at 0.
- G0 = 1 exactly while the state is CLEAR.

**Synchronizer.** Two flops, sync1 then sync2, reset to 0.

**Debouncer**, with deb_cnt of width $clog2(DEB_LEN+1).
- If sync2 == deb_lvl, deb_cnt = 0.
- Otherwise deb_cnt increments. When it reaches DEB_LEN, deb_lvl toggles and deb_cnt = 0 on that same edge.
- The debouncer runs in both FSM states.

**Prescaler**, with pre_cnt of width $clog2(PRESCALE).
- Held at 0 in CLEAR.
- In RUN with ENABLE = 1: counts 0..PRESCALE-1 and wraps to 0.
- G1 is registered 1 on the edge where pre_cnt wraps.
- ENABLE = 0 holds pre_cnt at its value and forces G1 = 0.
- PRESCALE = 1 gives G1 = 1 every RUN cycle with ENABLE = 1.

**G2 output.** G2 = deb_lvl (or the latch, see Configuration), forced to 0 while in CLEAR.

**Reset values.** On RST: G0 = 1, G1 = 0, G2 = 0. All counters, synchronizer flops, deb_lvl and the latch are 0.

## Timing
- RST deasserted before edge 1: G0 = 1 through edge CLR_LEN-1 and falls at edge CLR_LEN.
- First G1 pulse: at RUN edge PRESCALE, with ENABLE held high.
- SENSOR step: must be stable before edge k.
  - sync2 updates at edge k+1.
  - G2 changes at edge k+1+DEB_LEN.
  - Total latency: DEB_LEN+2 edges.
- Glitch shorter than DEB_LEN synchronized cycles: no G2 change; deb_cnt returns to 0.
- CLR_REQ and a pending G1 wrap on the same edge: the clear wins. G1 = 0 and pre_cnt = 0.
- RST asserted mid-count: all state clears immediately, without waiting for CK.
- Outputs change only on CK edges, except during RST assertion.

## Configuration
- Macro: TLC_REQ_LATCH_EN.
- Defined:
  - A deb_lvl 0->1 transition sets a sticky req_latch, and G2 = req_latch.
  - req_latch clears on the edge after a G1 pulse, unless a new deb_lvl rising transition occurs on that same edge; set wins.
  - req_latch clears in CLEAR.
- Undefined: no latch; G2 = deb_lvl masked by CLEAR.

## Test plan
- **Reset/clear.** Defaults; RST pulse then release → G0 = 1 for 8 edges, low at edge 8; G1 = 0 and G2 = 0 throughout.
- **Tick.** PRESCALE = 16, ENABLE = 1 for 64 RUN cycles → four G1 pulses, each 1 cycle wide, 16 cycles apart. ENABLE = 0 for 5 cycles mid-count delays the next pulse by exactly 5.
- **Debounce.** SENSOR 0→1 held → G2 = 1 at 6 edges. A 3-cycle SENSOR pulse → G2 stays 0.
- **Clear request.** CLR_REQ = 1 for one cycle in RUN → G0 = 1 for 8 edges, pre_cnt = 0, G2 = 0 during clear. Then deb_lvl reappears on G2.
- **Collision.** CLR_REQ on the wrap edge → no G1 pulse. RST asserted mid-debounce → G2 = 0 immediately.
- **Latch (TLC_REQ_LATCH_EN).** SENSOR high for 10 cycles then low → G2 stays 1 until the edge after the next G1 pulse, then 0.

Source files
------------

// File: rtl/tlc_input_cond.sv
// -----------------------------------------------------------------------------
// tlc_input_cond
// Input-conditioning front end for the s444 traffic-light controller. It
// produces the controller's three primary inputs from a raw asynchronous
// sensor line, all in the CK domain:
//   G0 - clear: high after reset or a clear request, for CLR_LEN edges
//   G1 - timebase tick: one-CK-wide pulse every PRESCALE enabled RUN cycles
//   G2 - request: SENSOR synchronized (2 flops) and debounced (DEB_LEN samples)
//
// Parameters:
//   PRESCALE  CK cycles per G1 tick (>= 1)
//   DEB_LEN   consecutive disagreeing samples needed to flip the request (>= 1)
//   CLR_LEN   CK edges G0 is held after reset / clear request (>= 1)
//
// Ports:
//   CK       in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   SENSOR   in   raw asynchronous request line
//   ENABLE   in   1 = prescaler counts, 0 = prescaler holds and G1 = 0
//   CLR_REQ  in   1 = re-enter the clear sequence
//   G0       out  registered clear
//   G1       out  registered tick pulse
//   G2       out  registered conditioned request
//
// Optional feature: define TLC_REQ_LATCH_EN to make the request sticky. A
// rising debounced level sets a latch that holds G2 high until the edge after
// the next G1 pulse (a fresh rising level on that edge keeps it set).
// -----------------------------------------------------------------------------
module tlc_input_cond #(
  parameter int PRESCALE = 16,
  parameter int DEB_LEN  = 4,
  parameter int CLR_LEN  = 8
) (
  input  logic CK,
  input  logic RST,
  input  logic SENSOR,
  input  logic ENABLE,
  input  logic CLR_REQ,
  output logic G0,
  output logic G1,
  output logic G2
);

  localparam int CLR_W = $clog2(CLR_LEN + 1);
  localparam int DEB_W = $clog2(DEB_LEN + 1);
  // A single-state prescaler still needs a one-bit counter to be legal.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_LEN - 1);
  localparam logic [CLR_W-1:0] CLR_ZERO = CLR_W'(0);
  localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LEN - 1);
  localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CLR_W-1:0]   clr_cnt_r;
  logic [CLR_W-1:0]   clr_cnt_nxt_s;
  logic               sync1_r;
  logic               sync2_r;
  logic [DEB_W-1:0]   deb_cnt_r;
  logic [DEB_W-1:0]   deb_cnt_nxt_s;
  logic               deb_lvl_r;
  logic               deb_lvl_nxt_s;
  logic [PRE_W-1:0]   pre_cnt_r;
  logic [PRE_W-1:0]   pre_cnt_nxt_s;
  logic               g0_r;
  logic               g1_r;
  logic               g2_r;
  logic               g1_nxt_s;
  logic               g2_src_s;
  logic               g2_nxt_s;

  // Clear FSM next state: count CLR_LEN edges in CLEAR, restart on CLR_REQ.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (CLR_REQ) begin
          clr_cnt_nxt_s = CLR_ZERO;
        end else if (clr_cnt_r == CLR_LAST) begin
          // This edge is the one where the count would reach CLR_LEN.
          state_nxt_s   = ST_RUN;
          clr_cnt_nxt_s = CLR_ZERO;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + CLR_ONE;
        end
      end
      ST_RUN: begin
        if (CLR_REQ) begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = CLR_ZERO;
        end else begin
          clr_cnt_nxt_s = CLR_ZERO;
        end
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_cnt_nxt_s = CLR_ZERO;
      end
    endcase
  end

  // Prescaler next state; a clear request beats a wrap on the same edge.
  always_comb begin
    pre_cnt_nxt_s = pre_cnt_r;
    g1_nxt_s      = 1'b0;
    if ((state_r != ST_RUN) || CLR_REQ) begin
      pre_cnt_nxt_s = PRE_ZERO;
    end else if (ENABLE) begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_nxt_s = PRE_ZERO;
        g1_nxt_s      = 1'b1;
      end else begin
        pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r;
    end
  end

  // Debouncer next state: flip the level after DEB_LEN disagreeing samples.
  always_comb begin
    deb_cnt_nxt_s = deb_cnt_r;
    deb_lvl_nxt_s = deb_lvl_r;
    if (sync2_r == deb_lvl_r) begin
      deb_cnt_nxt_s = DEB_ZERO;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_lvl_nxt_s = ~deb_lvl_r;
      deb_cnt_nxt_s = DEB_ZERO;
    end else begin
      deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
    end
  end

`ifdef TLC_REQ_LATCH_EN
  logic req_latch_r;
  logic req_latch_nxt_s;

  // Sticky request: set on a rising level, cleared the edge after a tick.
  always_comb begin
    req_latch_nxt_s = req_latch_r;
    if (state_nxt_s == ST_CLEAR) begin
      req_latch_nxt_s = 1'b0;
    end else if (deb_lvl_nxt_s && !deb_lvl_r) begin
      req_latch_nxt_s = 1'b1;
    end else if (g1_r) begin
      req_latch_nxt_s = 1'b0;
    end else begin
      req_latch_nxt_s = req_latch_r;
    end
  end

  // Sticky request register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      req_latch_r <= 1'b0;
    end else begin
      req_latch_r <= req_latch_nxt_s;
    end
  end

  assign g2_src_s = req_latch_nxt_s;
`else
  assign g2_src_s = deb_lvl_nxt_s;
`endif

  // G2 follows the request source on the same edge, masked while clearing.
  always_comb begin
    g2_nxt_s = 1'b0;
    if (state_nxt_s == ST_RUN) begin
      g2_nxt_s = g2_src_s;
    end else begin
      g2_nxt_s = 1'b0;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= CLR_ZERO;
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      deb_cnt_r <= DEB_ZERO;
      deb_lvl_r <= 1'b0;
      pre_cnt_r <= PRE_ZERO;
      g0_r      <= 1'b1;
      g1_r      <= 1'b0;
      g2_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
      sync1_r   <= SENSOR;
      sync2_r   <= sync1_r;
      deb_cnt_r <= deb_cnt_nxt_s;
      deb_lvl_r <= deb_lvl_nxt_s;
      pre_cnt_r <= pre_cnt_nxt_s;
      g0_r      <= (state_nxt_s == ST_CLEAR);
      g1_r      <= g1_nxt_s;
      g2_r      <= g2_nxt_s;
    end
  end

  assign G0 = g0_r;
  assign G1 = g1_r;
  assign G2 = g2_r;

endmodule
